// File: rtl/cpu_flash_bridge_if.sv
// Bus bundle between the 6809 / flash controller side and cpu_flash_bridge.
// master drives the CPU and controller inputs; slave is the bridge itself.
interface cpu_flash_bridge_if;
  logic        i_E;
  logic [15:0] i_ADDRESS_BUS;
  logic        i_RW;
  logic        i_MemoryReady;
  logic [7:0]  i_spi_data;
  logic        o_spi_ce;
  logic        o_MRDY;
  logic [7:0]  o_cpu_data;
  logic        o_data_oe;
  logic        o_error;

  modport master (
    output i_E, i_ADDRESS_BUS, i_RW, i_MemoryReady, i_spi_data,
    input  o_spi_ce, o_MRDY, o_cpu_data, o_data_oe, o_error
  );

  modport slave (
    input  i_E, i_ADDRESS_BUS, i_RW, i_MemoryReady, i_spi_data,
    output o_spi_ce, o_MRDY, o_cpu_data, o_data_oe, o_error
  );
endinterface

// File: rtl/cpu_flash_bridge.sv
// Stretches 6809 cycles in the flash window while a serial flash controller fetches the byte.
// Optional macro FLASH_WRITE_PROTECT_EN rejects window writes and flags them on o_error.
module cpu_flash_bridge #(
  parameter logic [3:0] WINDOW_BASE  = 4'hE,
  parameter int         ACK_TIMEOUT  = 16,
  parameter int         BUSY_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  cpu_flash_bridge_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, BUSY, HOLD} state_e;

  localparam logic [7:0] ACK_LAST  = 8'(ACK_TIMEOUT - 1);
  localparam logic [7:0] BUSY_LAST = 8'(BUSY_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic       eMeta_q, eSync_q, eDelay_q;
  logic       rw_q, rw_d;
  logic [7:0] cnt_q, cnt_d;
  logic       spiCe_q, spiCe_d;
  logic       mrdy_q, mrdy_d;
  logic [7:0] cpuData_q, cpuData_d;
  logic       dataOe_q, dataOe_d;
  logic       error_q, error_d;

  logic       eRise, eFall, windowHit, blockWrite;
  logic [7:0] cntInc;

  assign eRise     = eSync_q & ~eDelay_q;
  assign eFall     = ~eSync_q & eDelay_q;
  assign windowHit = (bus.i_ADDRESS_BUS[15:12] == WINDOW_BASE);
  assign cntInc    = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

`ifdef FLASH_WRITE_PROTECT_EN
  assign blockWrite = ~bus.i_RW;
`else
  assign blockWrite = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      eMeta_q   <= 1'b0;
      eSync_q   <= 1'b0;
      eDelay_q  <= 1'b0;
      rw_q      <= 1'b1;
      cnt_q     <= 8'h00;
      spiCe_q   <= 1'b0;
      mrdy_q    <= 1'b1;
      cpuData_q <= 8'h00;
      dataOe_q  <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      eMeta_q   <= bus.i_E;
      eSync_q   <= eMeta_q;
      eDelay_q  <= eSync_q;
      rw_q      <= rw_d;
      cnt_q     <= cnt_d;
      spiCe_q   <= spiCe_d;
      mrdy_q    <= mrdy_d;
      cpuData_q <= cpuData_d;
      dataOe_q  <= dataOe_d;
      error_q   <= error_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rw_d      = rw_q;
    cnt_d     = cnt_q;
    spiCe_d   = spiCe_q;
    mrdy_d    = mrdy_q;
    cpuData_d = cpuData_q;
    dataOe_d  = dataOe_q;
    error_d   = error_q;

    case (state_q)
      IDLE: begin
        if (eRise && windowHit) begin
          if (blockWrite) begin
            error_d = 1'b1;
          end else begin
            rw_d     = bus.i_RW;
            cnt_d    = 8'h00;
            spiCe_d  = 1'b1;
            mrdy_d   = 1'b0;
            dataOe_d = 1'b0;
            state_d  = REQ;
          end
        end
      end
      REQ: begin
        if (!bus.i_MemoryReady) begin
          spiCe_d = 1'b0;
          cnt_d   = 8'h00;
          state_d = BUSY;
        end else if (cnt_q >= ACK_LAST) begin
          error_d   = 1'b1;
          spiCe_d   = 1'b0;
          mrdy_d    = 1'b1;
          cpuData_d = 8'hFF;
          dataOe_d  = 1'b0;
          state_d   = HOLD;
        end else begin
          cnt_d = cntInc;
        end
      end
      BUSY: begin
        if (bus.i_MemoryReady) begin
          if (rw_q) cpuData_d = bus.i_spi_data;
          mrdy_d   = 1'b1;
          dataOe_d = rw_q;
          state_d  = HOLD;
        end else if (cnt_q >= BUSY_LAST) begin
          error_d   = 1'b1;
          spiCe_d   = 1'b0;
          mrdy_d    = 1'b1;
          cpuData_d = 8'hFF;
          dataOe_d  = 1'b0;
          state_d   = HOLD;
        end else begin
          cnt_d = cntInc;
        end
      end
      HOLD: begin
        // Only the end of the CPU cycle releases the bus; a fresh E-rise here is dropped.
        if (eFall) begin
          dataOe_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.o_spi_ce   = spiCe_q;
  assign bus.o_MRDY     = mrdy_q;
  assign bus.o_cpu_data = cpuData_q;
  assign bus.o_data_oe  = dataOe_q;
  assign bus.o_error    = error_q;

endmodule

// File: tb/tb_cpu_flash_bridge.sv
// Directed bench for cpu_flash_bridge; acts as both the 6809 and the flash controller.
// Write-path expectations follow FLASH_WRITE_PROTECT_EN when it is defined.
module tb_cpu_flash_bridge;

  logic clk;
  logic reset;
  cpu_flash_bridge_if bus ();

  cpu_flash_bridge dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  int   cePulses = 0;
  logic cePrev = 1'b0;
  logic sawCe, sawOe, sawMrdyLow, sawMrdyHigh;

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Every wait goes through here so pulse counts and sticky flags see each cycle.
  task automatic step();
    @(negedge clk);
    if (bus.o_spi_ce && !cePrev) cePulses++;
    cePrev = bus.o_spi_ce;
    if (bus.o_spi_ce)  sawCe = 1'b1;
    if (bus.o_data_oe) sawOe = 1'b1;
    if (!bus.o_MRDY)   sawMrdyLow = 1'b1;
    if (bus.o_MRDY)    sawMrdyHigh = 1'b1;
  endtask

  task automatic clearFlags();
    sawCe = 1'b0; sawOe = 1'b0; sawMrdyLow = 1'b0; sawMrdyHigh = 1'b0;
  endtask

  task automatic waitCe(input string tag);
    int n = 0;
    while (!bus.o_spi_ce && n < 20) begin
      step();
      n++;
    end
    checkOutput({tag, "_ce_seen"}, 16'(bus.o_spi_ce), 16'd1);
  endtask

  task automatic applyStimulus(input logic [15:0] addr, input logic rw,
                               input logic [7:0] dataByte, input int busyCycles);
    bus.i_ADDRESS_BUS = addr;
    bus.i_RW          = rw;
    bus.i_E           = 1'b1;
    waitCe("txn");
    repeat (2) step();
    bus.i_MemoryReady = 1'b0;
    repeat (busyCycles) step();
    bus.i_spi_data    = dataByte;
    bus.i_MemoryReady = 1'b1;
    step();
    bus.i_E = 1'b0;
    repeat (6) step();
  endtask

  initial begin
    clearFlags();
    reset             = 1'b0;
    bus.i_E           = 1'b0;
    bus.i_ADDRESS_BUS = 16'h0000;
    bus.i_RW          = 1'b1;
    bus.i_MemoryReady = 1'b1;
    bus.i_spi_data    = 8'h00;
    repeat (3) step();
    checkOutput("rst_ce",    16'(bus.o_spi_ce),   16'd0);
    checkOutput("rst_mrdy",  16'(bus.o_MRDY),     16'd1);
    checkOutput("rst_data",  16'(bus.o_cpu_data), 16'h00);
    checkOutput("rst_oe",    16'(bus.o_data_oe),  16'd0);
    checkOutput("rst_error", 16'(bus.o_error),    16'd0);
    reset = 1'b1;
    repeat (2) step();

    // Single read at 0xE123 with an 80-cycle controller fetch.
    bus.i_ADDRESS_BUS = 16'hE123;
    bus.i_RW          = 1'b1;
    bus.i_E           = 1'b1;
    waitCe("rd1");
    checkOutput("rd1_mrdy_low", 16'(bus.o_MRDY), 16'd0);
    step();
    checkOutput("rd1_ce_hold1", 16'(bus.o_spi_ce), 16'd1);
    step();
    checkOutput("rd1_ce_hold2", 16'(bus.o_spi_ce), 16'd1);
    bus.i_MemoryReady = 1'b0;
    step();
    checkOutput("rd1_ce_drop", 16'(bus.o_spi_ce), 16'd0);
    clearFlags();
    repeat (80) step();
    checkOutput("rd1_mrdy_stretch", 16'(sawMrdyHigh), 16'd0);
    checkOutput("rd1_no_ce_busy",   16'(sawCe),       16'd0);
    bus.i_spi_data    = 8'h5A;
    bus.i_MemoryReady = 1'b1;
    step();
    checkOutput("rd1_mrdy_release", 16'(bus.o_MRDY),     16'd1);
    checkOutput("rd1_data",         16'(bus.o_cpu_data), 16'h5A);
    checkOutput("rd1_oe_on",        16'(bus.o_data_oe),  16'd1);
    repeat (3) step();
    checkOutput("rd1_oe_held", 16'(bus.o_data_oe), 16'd1);
    bus.i_E = 1'b0;
    step();
    checkOutput("rd1_oe_sync_lag", 16'(bus.o_data_oe), 16'd1);
    repeat (4) step();
    checkOutput("rd1_oe_off", 16'(bus.o_data_oe), 16'd0);

    // Read outside the window must leave every output alone.
    clearFlags();
    bus.i_ADDRESS_BUS = 16'h8000;
    bus.i_E = 1'b1;
    repeat (8) step();
    bus.i_E = 1'b0;
    repeat (8) step();
    checkOutput("miss_ce",   16'(sawCe),          16'd0);
    checkOutput("miss_mrdy", 16'(sawMrdyLow),     16'd0);
    checkOutput("miss_oe",   16'(sawOe),          16'd0);
    checkOutput("miss_data", 16'(bus.o_cpu_data), 16'h5A);

    // Back-to-back window reads.
    begin
      int pulsesBefore;
      pulsesBefore = cePulses;
      applyStimulus(16'hE001, 1'b1, 8'h11, 3);
      checkOutput("b2b_data1", 16'(bus.o_cpu_data), 16'h11);
      applyStimulus(16'hE002, 1'b1, 8'h22, 3);
      checkOutput("b2b_data2",  16'(bus.o_cpu_data),  16'h22);
      checkOutput("b2b_pulses", 16'(cePulses - pulsesBefore), 16'd2);
      checkOutput("b2b_oe_off", 16'(bus.o_data_oe),   16'd0);
    end

    // Window write at 0xEFFF.
    clearFlags();
`ifdef FLASH_WRITE_PROTECT_EN
    bus.i_ADDRESS_BUS = 16'hEFFF;
    bus.i_RW          = 1'b0;
    bus.i_E           = 1'b1;
    repeat (8) step();
    bus.i_E = 1'b0;
    repeat (6) step();
    checkOutput("wp_no_ce",   16'(sawCe),      16'd0);
    checkOutput("wp_mrdy",    16'(sawMrdyLow), 16'd0);
    checkOutput("wp_error",   16'(bus.o_error), 16'd1);
`else
    applyStimulus(16'hEFFF, 1'b0, 8'hA5, 4);
    checkOutput("wr_had_ce",  16'(sawCe),       16'd1);
    checkOutput("wr_stretch", 16'(sawMrdyLow),  16'd1);
    checkOutput("wr_no_oe",   16'(sawOe),       16'd0);
    checkOutput("wr_error",   16'(bus.o_error), 16'd0);
`endif
    checkOutput("wr_data_kept", 16'(bus.o_cpu_data), 16'h22);
    checkOutput("wr_mrdy_idle", 16'(bus.o_MRDY),     16'd1);
    bus.i_RW = 1'b1;

    // Reset asserted while the controller is busy.
    bus.i_ADDRESS_BUS = 16'hE010;
    bus.i_E = 1'b1;
    waitCe("rstb");
    step();
    bus.i_MemoryReady = 1'b0;
    repeat (3) step();
    checkOutput("rstb_busy_mrdy", 16'(bus.o_MRDY), 16'd0);
    reset = 1'b0;
    step();
    checkOutput("rstb_mrdy",  16'(bus.o_MRDY),     16'd1);
    checkOutput("rstb_ce",    16'(bus.o_spi_ce),   16'd0);
    checkOutput("rstb_error", 16'(bus.o_error),    16'd0);
    checkOutput("rstb_data",  16'(bus.o_cpu_data), 16'h00);
    bus.i_E = 1'b0;
    bus.i_MemoryReady = 1'b1;
    repeat (2) step();
    reset = 1'b1;
    repeat (2) step();

    // Controller never acknowledges: 16 cycles in REQ, then timeout.
    bus.i_ADDRESS_BUS = 16'hE000;
    bus.i_E = 1'b1;
    waitCe("tmo");
    repeat (15) step();
    checkOutput("tmo_not_yet", 16'(bus.o_error), 16'd0);
    checkOutput("tmo_ce_held", 16'(bus.o_spi_ce), 16'd1);
    step();
    checkOutput("tmo_error", 16'(bus.o_error),    16'd1);
    checkOutput("tmo_mrdy",  16'(bus.o_MRDY),     16'd1);
    checkOutput("tmo_data",  16'(bus.o_cpu_data), 16'hFF);
    checkOutput("tmo_ce",    16'(bus.o_spi_ce),   16'd0);
    bus.i_E = 1'b0;
    repeat (6) step();
    checkOutput("tmo_sticky", 16'(bus.o_error), 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_flash_bridge.md
CPU_FLASH_BRIDGE -- requirements
Module: cpu_flash_bridge

Interface
REQ-001 SHALL provide parameter WINDOW_BASE, default 4'hE, address bits [15:12] selecting the 4 KB flash window (0xE000-0xEFFF).
REQ-002 SHALL provide parameter ACK_TIMEOUT, default 16, max clk cycles in REQ waiting for controller acknowledge.
REQ-003 SHALL provide parameter BUSY_TIMEOUT, default 255, max clk cycles in BUSY waiting for controller completion.
REQ-004 clk  input  1  system clock, all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 i_E  input  1  6809 E clock, asynchronous to clk.
REQ-007 i_ADDRESS_BUS  input  16  6809 address bus.
REQ-008 i_RW  input  1  6809 R/W (1 = read).
REQ-009 i_MemoryReady  input  1  flash controller ready (0 = transaction in progress).
REQ-010 i_spi_data  input  8  read byte from flash controller.
REQ-011 o_spi_ce  output  1  request strobe to flash controller.
REQ-012 o_MRDY  output  1  to 6809 MRDY (0 = stretch cycle).
REQ-013 o_cpu_data  output  8  latched read byte to CPU data bus.
REQ-014 o_data_oe  output  1  enable for CPU data bus drivers.
REQ-015 o_error  output  1  sticky timeout flag.

Function
REQ-016 i_E SHALL pass through a 2-flop synchronizer; E-rise/E-fall SHALL be detected from synchronized stage 2 vs a stage-3 delay flop.
REQ-017 States SHALL be IDLE, REQ, BUSY, HOLD; all outputs registered.
REQ-018 IDLE: on E-rise with i_ADDRESS_BUS[15:12]==WINDOW_BASE, latch i_RW, drive o_MRDY=0 and o_spi_ce=1 next cycle, go REQ, clear timeout counter; non-matching addresses leave all outputs unchanged.
REQ-019 REQ: hold o_spi_ce=1 until i_MemoryReady==0, then o_spi_ce=0 next cycle, go BUSY; o_spi_ce SHALL never be 1 outside REQ.
REQ-020 BUSY: on i_MemoryReady==1, capture i_spi_data into o_cpu_data (reads only), set o_MRDY=1, o_data_oe=latched RW, go HOLD.
REQ-021 HOLD: on E-fall, o_data_oe=0, go IDLE; an E-rise arriving in HOLD SHALL be ignored.
REQ-022 Timeout counter 8 bits, saturating; REQ exceeding ACK_TIMEOUT or BUSY exceeding BUSY_TIMEOUT SHALL set o_error=1, o_spi_ce=0, o_MRDY=1, o_cpu_data=8'hFF, go HOLD.
REQ-023 o_error SHALL clear only on reset.
REQ-024 Write cycles SHALL follow the same sequence with o_data_oe kept 0 and o_cpu_data unchanged.

Reset
REQ-025 reset==0 SHALL force IDLE: o_spi_ce=0, o_MRDY=1, o_data_oe=0, o_cpu_data=8'h00, o_error=0, counter=0, synchronizer flops=0.
REQ-026 reset asserted mid-transaction SHALL take priority over all state transitions on that edge.

Configuration
REQ-027 Macro FLASH_WRITE_PROTECT_EN defined: window write cycles SHALL be ignored (no o_spi_ce, o_MRDY stays 1, state stays IDLE) and set o_error=1.
REQ-028 Macro undefined: writes SHALL proceed per REQ-024 and never set o_error.

Verification
REQ-029 Read 0xE123, controller drops ready 2 cycles after ce, returns ready 80 cycles later with 0x5A -> o_spi_ce high exactly until ack+1, o_MRDY low for whole transaction, o_cpu_data=0x5A, o_data_oe=1 until E-fall.
REQ-030 Read 0x8000 -> o_spi_ce, o_MRDY, o_data_oe unchanged for full E cycle.
REQ-031 Read 0xE000, controller never acks -> o_error=1 after 16 cycles in REQ, o_MRDY=1, o_cpu_data=0xFF.
REQ-032 Write 0xEFFF: macro undefined -> full handshake, o_data_oe stays 0; macro defined -> no o_spi_ce, o_error=1.
REQ-033 reset=0 asserted during BUSY -> next cycle IDLE, o_MRDY=1, o_spi_ce=0, o_error=0.
REQ-034 Back-to-back window reads on consecutive E cycles 0xE001 then 0xE002 -> two distinct ce pulses, second captured byte replaces first.
